// File: rtl/fft_reorder_pkg.sv
// Shared types and index helpers for the FFT output reorder buffer.
package fft_reorder_pkg;

    typedef enum logic [1:0] {
        HALF_EMPTY    = 2'd0,
        HALF_FILLING  = 2'd1,
        HALF_FULL     = 2'd2,
        HALF_DRAINING = 2'd3
    } half_state_t;

    function automatic int log2_of(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int bitrev(input int value, input int bits);
        int r;
        r = 0;
        for (int i = 0; i < bits; i++) begin
            if (((value >> i) & 1) != 0) r = r | (1 << (bits - 1 - i));
        end
        return r;
    endfunction

    // Skewing by the top two index bits keeps both write and read beats conflict-free.
    function automatic int bank_index(input int lane, input int j, input int log2n);
        return (lane + (j >> (log2n - 2))) & 3;
    endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// Simple dual-port RAM: one write port, one registered read port.
module fft_reorder_bank #(
    parameter int WIDTH = 30,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset; every location is written before it is read.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/fft_reorder.sv
// Bit-reversed to natural-order reorder buffer, ping-pong halves over four banks.
// Optional start-of-frame checking is enabled by defining FFT_REORDER_SOF_CHECK_EN.
module fft_reorder
    import fft_reorder_pkg::*;
#(
    parameter int NBITS_OUT = 15,
    parameter int N         = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2*NBITS_OUT-1:0] in0_up,
    input  logic [2*NBITS_OUT-1:0] in0_down,
    input  logic [2*NBITS_OUT-1:0] in1_up,
    input  logic [2*NBITS_OUT-1:0] in1_down,
    input  logic                   in_valid,
    output logic                   in_ready,
`ifdef FFT_REORDER_SOF_CHECK_EN
    input  logic                   in_sof,
    output logic                   sof_err,
`endif
    output logic [2*NBITS_OUT-1:0] out_data0,
    output logic [2*NBITS_OUT-1:0] out_data1,
    output logic [2*NBITS_OUT-1:0] out_data2,
    output logic [2*NBITS_OUT-1:0] out_data3,
    output logic                   out_valid,
    input  logic                   out_ready
);
    localparam int W     = 2 * NBITS_OUT;
    localparam int LOG2N = log2_of(N);
    localparam int CW    = LOG2N - 2;
    localparam int AW    = LOG2N - 1;
    localparam logic [CW-1:0] LAST = CW'(N / 4 - 1);

    half_state_t     state_q [2];
    half_state_t     state_d [2];
    logic            wr_half, wr_half_d, rd_half, rd_half_d;
    logic [CW-1:0]   wr_cnt, wr_cnt_d, wr_c, rd_cnt, rd_cnt_d;
    logic            wr_en, rd_en, space, pop, push, s1_valid;
    logic [1:0]      occ;
    logic [2:0]      fill;
    logic [W-1:0]    lane [4];
    logic [W-1:0]    wdata_b [4];
    logic [W-1:0]    rdata_b [4];
    logic [W-1:0]    push_data [4];
    logic [W-1:0]    head [4];
    logic [W-1:0]    skid [4];
    logic [AW-1:0]   raddr_b [4];
    logic [1:0]      rd_sel_d [4];
    logic [1:0]      rd_sel_q [4];

    assign lane[0] = in0_up;
    assign lane[1] = in0_down;
    assign lane[2] = in1_up;
    assign lane[3] = in1_down;

    assign in_ready  = (state_q[wr_half] == HALF_EMPTY) || (state_q[wr_half] == HALF_FILLING);
    assign wr_en     = in_valid && in_ready;
    assign out_valid = (occ != 2'd0);
    assign pop       = out_valid && out_ready;
    assign push      = s1_valid;
    // Entries in flight (RAM stage plus output/skid) after this cycle's pop.
    assign fill      = {1'b0, occ} + {2'b00, s1_valid} - {2'b00, pop};
    assign space     = (fill < 3'd2);
    assign rd_en     = ((state_q[rd_half] == HALF_FULL) || (state_q[rd_half] == HALF_DRAINING)) && space;

`ifdef FFT_REORDER_SOF_CHECK_EN
    assign wr_c = in_sof ? '0 : wr_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sof_err <= 1'b0;
        end else if (wr_en && (in_sof != (wr_cnt == '0))) begin
            sof_err <= 1'b1;
        end
    end
`else
    assign wr_c = wr_cnt;
`endif

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        for (int b = 0; b < 4; b++) wdata_b[b] = '0;
        for (int l = 0; l < 4; l++) begin
            wdata_b[2'(bank_index(l, 4 * int'(wr_c) + l, LOG2N))] = lane[l];
        end
    end

    always_comb begin
        int jq;
        for (int b = 0; b < 4; b++) raddr_b[b] = '0;
        for (int q = 0; q < 4; q++) begin
            jq          = bitrev(4 * int'(rd_cnt) + q, LOG2N);
            rd_sel_d[q] = 2'(bank_index(jq & 3, jq, LOG2N));
            raddr_b[rd_sel_d[q]] = {rd_half, CW'(jq >> 2)};
        end
    end

    always_comb begin
        for (int q = 0; q < 4; q++) push_data[q] = rdata_b[rd_sel_q[q]];
    end

    for (genvar b = 0; b < 4; b++) begin : g_bank
        fft_reorder_bank #(.WIDTH(W), .AW(AW)) u_bank (
            .clk   (clk),
            .we    (wr_en),
            .waddr ({wr_half, wr_c}),
            .wdata (wdata_b[b]),
            .re    (rd_en),
            .raddr (raddr_b[b]),
            .rdata (rdata_b[b])
        );
    end

    always_comb begin
        state_d   = state_q;
        wr_half_d = wr_half;
        wr_cnt_d  = wr_cnt;
        rd_half_d = rd_half;
        rd_cnt_d  = rd_cnt;
        if (wr_en) begin
            if (wr_c == LAST) begin
                state_d[wr_half] = HALF_FULL;
                wr_half_d        = ~wr_half;
                wr_cnt_d         = '0;
            end else begin
                state_d[wr_half] = HALF_FILLING;
                wr_cnt_d         = wr_c + 1'b1;
            end
        end
        if (rd_en) begin
            if (rd_cnt == LAST) begin
                state_d[rd_half] = HALF_EMPTY;
                rd_half_d        = ~rd_half;
                rd_cnt_d         = '0;
            end else begin
                state_d[rd_half] = HALF_DRAINING;
                rd_cnt_d         = rd_cnt + 1'b1;
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q[0] <= HALF_EMPTY;
            state_q[1] <= HALF_EMPTY;
            wr_half    <= 1'b0;
            wr_cnt     <= '0;
            rd_half    <= 1'b0;
            rd_cnt     <= '0;
            s1_valid   <= 1'b0;
            occ        <= 2'd0;
            for (int q = 0; q < 4; q++) begin
                head[q] <= '0;
                skid[q] <= '0;
            end
        end else begin
            state_q  <= state_d;
            wr_half  <= wr_half_d;
            wr_cnt   <= wr_cnt_d;
            rd_half  <= rd_half_d;
            rd_cnt   <= rd_cnt_d;
            s1_valid <= rd_en;
            occ      <= 2'(fill);
            if (pop && occ == 2'd2) begin
                head <= skid;
                if (push) skid <= push_data;
            end else if (pop || occ == 2'd0) begin
                if (push) head <= push_data;
            end else if (push) begin
                skid <= push_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) rd_sel_q <= rd_sel_d;
    end

    assign out_data0 = head[0];
    assign out_data1 = head[1];
    assign out_data2 = head[2];
    assign out_data3 = head[3];

endmodule
